// File: rtl/draw_text_16x16.sv
// draw_text_16x16
// Overlays a 16x16-cell text box (8x16 px glyphs) on the incoming VGA pixel stream.
// Stage 1 produces the cell address and glyph row for the external character/font ROMs.
// Stage 2 waits for the registered font row to come back.
// Stage 3 composites the glyph pixel over the delayed RGB and blanks it outside the active area.
// Every timing signal is delayed by the same three stages, so hcount/vcount/sync/blank stay
// aligned with rgb_out.

module draw_text_16x16 #(
   parameter logic [10:0] XPOS       = 11'd0,
   parameter logic [10:0] YPOS       = 11'd0,
   parameter logic [11:0] FONT_COLOR = 12'hFFF
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic [10:0] vcount_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblnk_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   input  logic [7:0]  char_pixels,
   output logic [7:0]  char_xy,
   output logic [3:0]  char_line,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        hblnk_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out
);

   // Box end coordinates are one bit wider so a box near the raster edge cannot wrap.
   localparam logic [11:0] X_END = {1'b0, XPOS} + 12'd128;
   localparam logic [11:0] Y_END = {1'b0, YPOS} + 12'd256;

   // Selects the glyph pixel for a column; bit 7 of the font row is the leftmost pixel.
   function automatic logic f_glyph_bit(input logic [7:0] row, input logic [2:0] idx);
      logic [2:0] pos;
      pos = 3'd7 - idx;
      return row[pos];
   endfunction

   // Box test and relative coordinates
   logic       w_in_x;
   logic       w_in_y;
   logic       w_in_box;
   logic [6:0] w_rel_x;
   logic [7:0] w_rel_y;

   // Stage 1 next values
   logic [7:0] w_char_xy_next;
   logic [3:0] w_char_line_next;
   logic [2:0] w_bit_idx_next;

   // Stage 1 registers
   logic [7:0]  r_char_xy;
   logic [3:0]  r_char_line;
   logic [2:0]  r_bit_idx1;
   logic        r_in_box1;
   logic [10:0] r_hcount1;
   logic [10:0] r_vcount1;
   logic        r_hsync1;
   logic        r_vsync1;
   logic        r_hblnk1;
   logic        r_vblnk1;
   logic [11:0] r_rgb1;

   // Stage 2 registers
   logic [2:0]  r_bit_idx2;
   logic        r_in_box2;
   logic [10:0] r_hcount2;
   logic [10:0] r_vcount2;
   logic        r_hsync2;
   logic        r_vsync2;
   logic        r_hblnk2;
   logic        r_vblnk2;
   logic [11:0] r_rgb2;

   // Stage 3 (output) registers
   logic [11:0] w_rgb_next;
   logic [10:0] r_hcount3;
   logic [10:0] r_vcount3;
   logic        r_hsync3;
   logic        r_vsync3;
   logic        r_hblnk3;
   logic        r_vblnk3;
   logic [11:0] r_rgb3;

   // Decide whether the current raster position lies inside the visible text box.
   always_comb begin
      // Only the low bits of the offsets are ever used, and low bits of a difference
      // depend only on the low bits of the operands.
      w_rel_x  = hcount_in[6:0] - XPOS[6:0];
      w_rel_y  = vcount_in[7:0] - YPOS[7:0];
      w_in_x   = ({1'b0, hcount_in} >= {1'b0, XPOS}) && ({1'b0, hcount_in} < X_END);
      w_in_y   = ({1'b0, vcount_in} >= {1'b0, YPOS}) && ({1'b0, vcount_in} < Y_END);
      w_in_box = w_in_x && w_in_y && !hblnk_in && !vblnk_in;
   end

   // Form the ROM address and pixel column; outside the box the address parks at cell 0.
   always_comb begin
      w_char_xy_next   = 8'h00;
      w_char_line_next = 4'h0;
      w_bit_idx_next   = w_rel_x[2:0];
      if (w_in_box) begin
         w_char_xy_next   = {w_rel_y[7:4], w_rel_x[6:3]};
         w_char_line_next = w_rel_y[3:0];
      end else begin
         w_char_xy_next   = 8'h00;
         w_char_line_next = 4'h0;
      end
   end

   // Stage 1: register ROM address, pixel column and the raw timing/colour inputs.
   always_ff @(posedge pclk) begin
      if (rst) begin
         r_char_xy   <= 8'h00;
         r_char_line <= 4'h0;
         r_bit_idx1  <= 3'd0;
         r_in_box1   <= 1'b0;
         r_hcount1   <= 11'd0;
         r_vcount1   <= 11'd0;
         r_hsync1    <= 1'b0;
         r_vsync1    <= 1'b0;
         r_hblnk1    <= 1'b0;
         r_vblnk1    <= 1'b0;
         r_rgb1      <= 12'h000;
      end else begin
         r_char_xy   <= w_char_xy_next;
         r_char_line <= w_char_line_next;
         r_bit_idx1  <= w_bit_idx_next;
         r_in_box1   <= w_in_box;
         r_hcount1   <= hcount_in;
         r_vcount1   <= vcount_in;
         r_hsync1    <= hsync_in;
         r_vsync1    <= vsync_in;
         r_hblnk1    <= hblnk_in;
         r_vblnk1    <= vblnk_in;
         r_rgb1      <= rgb_in;
      end
   end

   // Stage 2: hold everything one more cycle while the font ROM register fills.
   always_ff @(posedge pclk) begin
      if (rst) begin
         r_bit_idx2 <= 3'd0;
         r_in_box2  <= 1'b0;
         r_hcount2  <= 11'd0;
         r_vcount2  <= 11'd0;
         r_hsync2   <= 1'b0;
         r_vsync2   <= 1'b0;
         r_hblnk2   <= 1'b0;
         r_vblnk2   <= 1'b0;
         r_rgb2     <= 12'h000;
      end else begin
         r_bit_idx2 <= r_bit_idx1;
         r_in_box2  <= r_in_box1;
         r_hcount2  <= r_hcount1;
         r_vcount2  <= r_vcount1;
         r_hsync2   <= r_hsync1;
         r_vsync2   <= r_vsync1;
         r_hblnk2   <= r_hblnk1;
         r_vblnk2   <= r_vblnk1;
         r_rgb2     <= r_rgb1;
      end
   end

   // Composite: blanking wins, then a set glyph pixel inside the box, else pass-through.
   always_comb begin
      w_rgb_next = 12'h000;
      if (r_hblnk2 || r_vblnk2) begin
         w_rgb_next = 12'h000;
      end else if (r_in_box2 && f_glyph_bit(char_pixels, r_bit_idx2)) begin
         w_rgb_next = FONT_COLOR;
      end else begin
         w_rgb_next = r_rgb2;
      end
   end

   // Stage 3: register the composited colour and the aligned timing outputs.
   always_ff @(posedge pclk) begin
      if (rst) begin
         r_hcount3 <= 11'd0;
         r_vcount3 <= 11'd0;
         r_hsync3  <= 1'b0;
         r_vsync3  <= 1'b0;
         r_hblnk3  <= 1'b0;
         r_vblnk3  <= 1'b0;
         r_rgb3    <= 12'h000;
      end else begin
         r_hcount3 <= r_hcount2;
         r_vcount3 <= r_vcount2;
         r_hsync3  <= r_hsync2;
         r_vsync3  <= r_vsync2;
         r_hblnk3  <= r_hblnk2;
         r_vblnk3  <= r_vblnk2;
         r_rgb3    <= w_rgb_next;
      end
   end

   assign char_xy    = r_char_xy;
   assign char_line  = r_char_line;
   assign hcount_out = r_hcount3;
   assign vcount_out = r_vcount3;
   assign hsync_out  = r_hsync3;
   assign vsync_out  = r_vsync3;
   assign hblnk_out  = r_hblnk3;
   assign vblnk_out  = r_vblnk3;
   assign rgb_out    = r_rgb3;

endmodule

// File: tb/tb_draw_text_16x16.sv
// Testbench for draw_text_16x16: directed scenarios plus a randomized raster sweep,
// each cycle checked against a coordinate-level model of the text overlay.
`timescale 1ns/1ps

module tb_draw_text_16x16;

   localparam logic [10:0] XP = 11'd100;
   localparam logic [10:0] YP = 11'd50;
   localparam logic [11:0] FC = 12'hFFF;

   logic        pclk = 1'b0;
   logic        rst;
   logic [10:0] hcount_in;
   logic [10:0] vcount_in;
   logic        hsync_in;
   logic        vsync_in;
   logic        hblnk_in;
   logic        vblnk_in;
   logic [11:0] rgb_in;
   logic [7:0]  char_pixels;
   logic [7:0]  char_xy;
   logic [3:0]  char_line;
   logic [10:0] hcount_out;
   logic [10:0] vcount_out;
   logic        hsync_out;
   logic        vsync_out;
   logic        hblnk_out;
   logic        vblnk_out;
   logic [11:0] rgb_out;

   draw_text_16x16 #(.XPOS(XP), .YPOS(YP), .FONT_COLOR(FC)) dut (
      .pclk        (pclk),
      .rst         (rst),
      .hcount_in   (hcount_in),
      .vcount_in   (vcount_in),
      .hsync_in    (hsync_in),
      .vsync_in    (vsync_in),
      .hblnk_in    (hblnk_in),
      .vblnk_in    (vblnk_in),
      .rgb_in      (rgb_in),
      .char_pixels (char_pixels),
      .char_xy     (char_xy),
      .char_line   (char_line),
      .hcount_out  (hcount_out),
      .vcount_out  (vcount_out),
      .hsync_out   (hsync_out),
      .vsync_out   (vsync_out),
      .hblnk_out   (hblnk_out),
      .vblnk_out   (vblnk_out),
      .rgb_out     (rgb_out)
   );

   always #5 pclk = ~pclk;

   int n_checks = 0;
   int n_errors = 0;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Input snapshot taken at each rising edge.
   typedef struct {
      logic [10:0] h;
      logic [10:0] v;
      logic        hs;
      logic        vs;
      logic        hb;
      logic        vb;
      logic [11:0] rgb;
      logic        rst;
   } samp_t;

   samp_t hist[4];
   int    k = -1;
   logic [7:0] rom_pend = 8'h00;

   // Font ROM contents seen by both the environment and the model.
   function automatic logic [7:0] rom_row(input logic [7:0] xy, input logic [3:0] line);
      logic [7:0] t;
      if (xy == 8'h00 && line == 4'h0) return 8'hA0;
      t = xy * 8'd37;
      t = t + {4'd0, line} * 8'd91;
      return t ^ 8'h5A;
   endfunction

   function automatic bit model_inbox(input samp_t s);
      int h;
      int v;
      h = int'(s.h);
      v = int'(s.v);
      return (h >= int'(XP)) && (h < int'(XP) + 128) && (v >= int'(YP)) && (v < int'(YP) + 256)
             && !s.hb && !s.vb;
   endfunction

   // {row, col, line} of the cell under the pixel, zero outside the box.
   function automatic logic [11:0] model_char(input samp_t s);
      int rx;
      int ry;
      if (!model_inbox(s)) return 12'h000;
      rx = int'(s.h) - int'(XP);
      ry = int'(s.v) - int'(YP);
      return {4'(ry / 16), 4'(rx / 8), 4'(ry % 16)};
   endfunction

   function automatic logic [11:0] model_rgb(input samp_t s);
      logic [11:0] c;
      logic [7:0]  row;
      int          rx;
      if (s.hb || s.vb) return 12'h000;
      if (!model_inbox(s)) return s.rgb;
      c   = model_char(s);
      row = rom_row(c[11:4], c[3:0]);
      rx  = int'(s.h) - int'(XP);
      if (row[7 - (rx % 8)]) return FC;
      return s.rgb;
   endfunction

   // One pixel clock: snapshot inputs, check all outputs against the model, feed the font ROM.
   task automatic tick();
      samp_t s;
      samp_t o;
      bit    flushed;
      @(posedge pclk);
      s.h = hcount_in;  s.v = vcount_in;
      s.hs = hsync_in;  s.vs = vsync_in;
      s.hb = hblnk_in;  s.vb = vblnk_in;
      s.rgb = rgb_in;   s.rst = rst;
      k++;
      hist[k % 4] = s;
      @(negedge pclk);
      check_eq("char", 32'({char_xy, char_line}), s.rst ? 32'd0 : 32'(model_char(s)));
      o       = hist[(k + 2) % 4];
      flushed = s.rst || hist[(k + 3) % 4].rst || o.rst;
      check_eq("timing", 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
               flushed ? 32'd0 : 32'({o.h, o.v, o.hs, o.vs, o.hb, o.vb}));
      check_eq("rgb", 32'(rgb_out), flushed ? 32'd0 : 32'(model_rgb(o)));
      // Registered font ROM: the row for this address appears after the next edge.
      char_pixels = rom_pend;
      rom_pend    = rom_row(char_xy, char_line);
   endtask

   task automatic set_px(input int h, input int v, input bit hb, input bit vb, input logic [11:0] c);
      hcount_in = 11'(h);
      vcount_in = 11'(v);
      hblnk_in  = hb;
      vblnk_in  = vb;
      rgb_in    = c;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         hist[i].rst = 1'b1;
         hist[i].h = 11'd0; hist[i].v = 11'd0;
         hist[i].hs = 1'b0; hist[i].vs = 1'b0;
         hist[i].hb = 1'b0; hist[i].vb = 1'b0;
         hist[i].rgb = 12'h000;
      end
      rst = 1'b1;
      hsync_in = 1'b0;
      vsync_in = 1'b0;
      char_pixels = 8'h00;
      set_px(0, 0, 1'b0, 1'b0, 12'h000);
      repeat (3) tick();
      check_eq("reset_rgb", 32'(rgb_out), 32'd0);
      rst = 1'b0;

      // Box corners and right edge
      set_px(100, 50, 1'b0, 1'b0, 12'h123);
      tick();
      check_eq("tp_origin", 32'({char_xy, char_line}), 32'h000);
      set_px(227, 305, 1'b0, 1'b0, 12'h123);
      tick();
      check_eq("tp_corner", 32'({char_xy, char_line}), 32'hFFF);
      set_px(228, 305, 1'b0, 1'b0, 12'h123);
      tick();
      check_eq("tp_right_out", 32'(char_xy), 32'h00);

      // Glyph row 1010_0000 across the first cell
      for (int i = 0; i < 10; i++) begin
         set_px((i < 8) ? 100 + i : 300, 50, 1'b0, 1'b0, 12'h123);
         tick();
         if (i >= 2) begin
            check_eq("tp_row", 32'(rgb_out), (i - 2 == 0 || i - 2 == 2) ? 32'(FC) : 32'h123);
         end
      end

      // Single hsync pulse with counting hcount
      for (int i = 0; i < 12; i++) begin
         set_px(i, 60, 1'b0, 1'b0, 12'h456);
         hsync_in = (i == 5);
         tick();
         if (i >= 2) check_eq("tp_hsync", 32'(hsync_out), (i - 2 == 5) ? 32'd1 : 32'd0);
      end
      hsync_in = 1'b0;

      // Glyph pixel under horizontal blank
      set_px(100, 50, 1'b1, 1'b0, 12'h123);
      repeat (3) tick();
      check_eq("tp_blank", 32'(rgb_out), 32'd0);

      // Reset mid-line inside the box
      set_px(100, 50, 1'b0, 1'b0, 12'h123);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      check_eq("tp_rst_rgb", 32'(rgb_out), 32'd0);
      check_eq("tp_rst_hcount", 32'(hcount_out), 32'd0);
      rst = 1'b0;
      tick();
      check_eq("tp_rel1", 32'(rgb_out), 32'd0);
      tick();
      check_eq("tp_rel2", 32'(rgb_out), 32'd0);
      tick();
      check_eq("tp_rel3", 32'(rgb_out), 32'(FC));

      // Counting raster lines crossing the top of the box
      for (int v = 45; v < 57; v++) begin
         for (int h = 0; h < 800; h++) begin
            set_px(h, v, h >= 640, v >= 480, 12'($urandom));
            hsync_in = (h >= 656) && (h < 752);
            vsync_in = (v >= 490) && (v < 492);
            tick();
         end
      end

      // Random pixels, biased towards the box and its edges, with occasional resets
      for (int n = 0; n < 15000; n++) begin
         int h;
         int v;
         if ($urandom_range(1, 0) == 1) begin
            h = int'($urandom_range(240, 90));
            v = int'($urandom_range(320, 40));
         end else begin
            h = int'($urandom_range(799, 0));
            v = int'($urandom_range(627, 0));
         end
         set_px(h, v, (h >= 640) || ($urandom_range(15, 0) == 0),
                (v >= 480) || ($urandom_range(15, 0) == 0), 12'($urandom));
         hsync_in = $urandom_range(7, 0) == 0;
         vsync_in = $urandom_range(7, 0) == 0;
         rst      = $urandom_range(399, 0) == 0;
         tick();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/draw_text_16x16.md
Name: draw_text_16x16

Overview:
- Pixel-pipeline consumer for the 16x16 text screen.
- Walks the incoming VGA raster and generates the `char_xy` cell address and `char_line` font row for the character code ROM and font ROM.
- Takes back the 8-bit font row pixels and overlays `FONT_COLOR` glyph pixels on the incoming RGB stream.
- Sits in the display chain between the background/sprite drawers and the VGA output register.

Parameters:
- XPOS, 11'd0, left edge of the text box in pixels.
- YPOS, 11'd0, top edge of the text box in pixels.
- FONT_COLOR, 12'hFFF, RGB444 colour of set glyph pixels.

Ports:
- pclk  in  1  pixel clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- hcount_in  in  11  horizontal pixel count.
- vcount_in  in  11  vertical line count.
- hsync_in  in  1  horizontal sync.
- vsync_in  in  1  vertical sync.
- hblnk_in  in  1  horizontal blank.
- vblnk_in  in  1  vertical blank.
- rgb_in  in  12  incoming pixel colour.
- char_pixels  in  8  font row from the font ROM; registered in the font ROM, valid 1 cycle after `char_xy`/`char_line`; bit 7 is the leftmost pixel.
- char_xy  out  8  text cell address {row[3:0], col[3:0]}.
- char_line  out  4  glyph row within the cell, 0..15.
- hcount_out  out  11  delayed `hcount_in`.
- vcount_out  out  11  delayed `vcount_in`.
- hsync_out  out  1  delayed `hsync_in`.
- vsync_out  out  1  delayed `vsync_in`.
- hblnk_out  out  1  delayed `hblnk_in`.
- vblnk_out  out  1  delayed `vblnk_in`.
- rgb_out  out  12  composited pixel colour.

Behaviour:
- Single clock `pclk`; reset is synchronous and active-high on `rst`. All state is updated on the rising edge of `pclk`.
- Text box geometry:
  - 16 columns x 8 px = 128 px wide; 16 rows x 16 px = 256 px tall.
  - `in_box` = (XPOS <= hcount_in < XPOS+128) && (YPOS <= vcount_in < YPOS+256) && !hblnk_in && !vblnk_in.
  - Comparisons are 11-bit unsigned. XPOS+128 and YPOS+256 are computed as 12-bit values so there is no wrap.
- Relative coordinates: rel_x = hcount_in - XPOS and rel_y = vcount_in - YPOS, both 11-bit; used only when `in_box`.
- Stage 1 (registered):
  - When `in_box`: char_xy <= {rel_y[7:4], rel_x[6:3]}; char_line <= rel_y[3:0].
  - Otherwise: char_xy <= 8'h00; char_line <= 4'h0.
  - Also registers bit_idx1 <= rel_x[2:0], in_box1, and all six timing inputs plus `rgb_in`.
- External path: `char_xy` feeds the character code ROM (combinational), which feeds the font ROM address {char_code, char_line}. The font ROM output register presents `char_pixels` during stage 2.
- Stage 2 (registered): delays bit_idx, in_box, timing signals and rgb by one more cycle, giving bit_idx2, in_box2, rgb2, hblnk2, vblnk2 etc.
- Stage 3 (registered, output), evaluated in priority order:
  1. If hblnk2 || vblnk2: rgb_out <= 12'h000.
  2. Else if in_box2 && char_pixels[7 - bit_idx2]: rgb_out <= FONT_COLOR.
  3. Else: rgb_out <= rgb2.
  - All timing outputs take their stage-2 values.
- Latency:
  - `hcount_out`, `vcount_out`, syncs, blanks and `rgb_out` lag their inputs by exactly 3 `pclk` cycles.
  - `char_xy`/`char_line` lag by 1 cycle.
- Reset:
  - Every output and every pipeline register is forced to 0: `char_xy`=8'h00, `char_line`=0, `rgb_out`=0, counts=0, syncs=0, blanks=0.
  - Reset asserted mid-frame flushes the pipeline immediately.
  - After release, outputs reflect post-reset inputs from cycle 3 onward; stages not yet refilled emit zeros.
- Boundaries:
  - hcount_in = XPOS+127 maps to col 15, bit_idx 7. hcount_in = XPOS+128 is outside the box.
  - vcount_in = YPOS+255 maps to row 15, line 15.
  - No state survives across frames; behaviour depends only on the current inputs.

Test Plan:
- XPOS=100, YPOS=50; drive hcount=100, vcount=50, blanks=0 -> next cycle `char_xy`=8'h00, `char_line`=0.
- hcount=227, vcount=305 -> `char_xy`=8'hFF, `char_line`=15. Then hcount=228 -> `char_xy`=8'h00 (outside box).
- hcount=100..107 on vcount=50, char_pixels=8'b1010_0000, rgb_in=12'h123 -> `rgb_out` 3 cycles later is FONT_COLOR, 12'h123, FONT_COLOR, then 12'h123 for the remaining five pixels.
- Single-cycle `hsync_in` pulse and counting `hcount_in` -> `hsync_out`/`hcount_out` identical, delayed exactly 3 cycles. Check in-box glyph pixels with hblnk_in=1 -> `rgb_out`=12'h000.
- Assert `rst` for 1 cycle mid-line inside the box -> next cycle all outputs 0. Then `rgb_out` stays 0 for 2 more cycles and matches expected compositing from the 3rd cycle after release.
- Random raster sweep over a full 800x628 frame -> scoreboard model of the compositing rules matches `rgb_out` and `char_xy` on every cycle.
